// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg
//   Shared definitions for the timer arbiter: arbiter state encoding,
//   default field widths, the largest legal seconds value and a small
//   round-robin pointer helper.
package timer_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int MIN_W_DEF = 3;
  localparam int SEC_W_DEF = 6;
  localparam int MAX_SEC   = 59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Requester index that follows idx in round-robin order over n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   the pointer, wrapping around.
// Ports
//   i_req   : request vector, one bit per requester
//   i_ptr   : requester index that has highest priority this cycle
//   o_pick  : one-hot selected requester (all zero when nothing requests)
//   o_valid : at least one request was selected
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_valid && i_req[wrap_add(i_ptr, k)]) begin
        o_pick[wrap_add(i_ptr, k)] = 1'b1;
        o_valid                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Shares one minute/second TIMER between N_REQ requesters. A requester
//   holds REQ with its preset; the arbiter grants round-robin, loads and
//   starts the TIMER, waits for a fresh TIME_UP rise and reports DONE.
//   Presets with seconds above 59 are rejected with ERR; a 0:00 preset
//   completes without touching the TIMER.
// Ports
//   SYSCLK, RST_B          : clock, asynchronous active-low reset
//   REQ, REQ_MIN, REQ_SEC  : per-requester level request and packed preset
//   GNT, DONE, ERR         : one-hot grant, completion pulse, reject pulse
//   BUSY                   : arbiter is not idle
//   TMR_MIN, TMR_SEC       : preset presented to the TIMER
//   TMR_START              : one-cycle TIMER load/start
//   TMR_TIME_UP            : TIMER expiry level
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant; pick next requester, reject bad presets
// ST_LOAD | grant held, TMR_START high for this single cycle
// ST_RUN  | waiting for a TIME_UP rise, abort if REQ drops
// ST_FIN  | DONE pulse issued at exit, grant released
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int MIN_W = MIN_W_DEF,
  parameter int SEC_W = SEC_W_DEF
) (
  input  logic                   SYSCLK,
  input  logic                   RST_B,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*MIN_W-1:0] REQ_MIN,
  input  logic [N_REQ*SEC_W-1:0] REQ_SEC,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic [N_REQ-1:0]       ERR,
  output logic                   BUSY,
  output logic [MIN_W-1:0]       TMR_MIN,
  output logic [SEC_W-1:0]       TMR_SEC,
  output logic                   TMR_START,
  input  logic                   TMR_TIME_UP
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_idx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] r_err;
  logic             r_busy;
  logic             r_tmr_start;
  logic [MIN_W-1:0] r_tmr_min;
  logic [SEC_W-1:0] r_tmr_sec;
  logic             r_tu_q;

  logic [N_REQ-1:0] w_pick;
  logic             w_valid;
  logic [PW-1:0]    w_pick_idx;
  logic [MIN_W-1:0] w_sel_min;
  logic [SEC_W-1:0] w_sel_sec;
  logic             w_sel_bad;
  logic             w_sel_zero;
  logic             w_req_held;
  logic             w_tu_rise;
  logic [PW-1:0]    w_ptr_after_pick;
  logic [PW-1:0]    w_ptr_after_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .i_req   (REQ),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    w_sel_min  = '0;
    w_sel_sec  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick[k]) begin
        w_pick_idx = PW'(k);
        w_sel_min  = REQ_MIN[k*MIN_W +: MIN_W];
        w_sel_sec  = REQ_SEC[k*SEC_W +: SEC_W];
      end
    end
  end

  assign w_sel_bad        = int'(w_sel_sec) > MAX_SEC;
  assign w_sel_zero       = (w_sel_min == '0) && (w_sel_sec == '0);
  assign w_req_held       = REQ[r_idx];
  // r_tu_q tracks the level at the previous edge, so a level already high
  // when RUN is entered never looks like a rise.
  assign w_tu_rise        = TMR_TIME_UP & ~r_tu_q;
  assign w_ptr_after_pick = PW'(rr_next(int'(w_pick_idx), N_REQ));
  assign w_ptr_after_idx  = PW'(rr_next(int'(r_idx), N_REQ));

  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_busy      <= 1'b0;
      r_tmr_start <= 1'b0;
      r_tmr_min   <= '0;
      r_tmr_sec   <= '0;
      r_tu_q      <= 1'b0;
    end else begin
      r_tu_q      <= TMR_TIME_UP;
      r_done      <= '0;
      r_err       <= '0;
      r_tmr_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            if (w_sel_bad) begin
              r_err    <= w_pick;
              r_rr_ptr <= w_ptr_after_pick;
            end else begin
              r_gnt  <= w_pick;
              r_idx  <= w_pick_idx;
              r_busy <= 1'b1;
              if (w_sel_zero) begin
                // nothing to time: the TIMER keeps its previous preset
                r_state <= ST_FIN;
              end else begin
                r_state     <= ST_LOAD;
                r_tmr_start <= 1'b1;
                r_tmr_min   <= w_sel_min;
                r_tmr_sec   <= w_sel_sec;
              end
            end
          end
        end
        ST_LOAD, ST_RUN: begin
          if (!w_req_held) begin
            // abandoned grant: the TIMER is left running, the next grant reloads it
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_ptr_after_idx;
            r_state  <= ST_IDLE;
          end else if (r_state == ST_LOAD) begin
            r_state <= ST_RUN;
          end else if (w_tu_rise) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_done   <= r_gnt;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_ptr_after_idx;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign BUSY      = r_busy;
  assign TMR_MIN   = r_tmr_min;
  assign TMR_SEC   = r_tmr_sec;
  assign TMR_START = r_tmr_start;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter
//   Directed scenarios plus randomized traffic for timer_arbiter, checked
//   every cycle against a transaction-level model of the arbiter.
module tb_timer_arbiter;

  localparam int N  = 4;
  localparam int MW = 3;
  localparam int SW = 6;

  logic            SYSCLK = 1'b0;
  logic            RST_B;
  logic [N-1:0]    REQ;
  logic [N*MW-1:0] REQ_MIN;
  logic [N*SW-1:0] REQ_SEC;
  logic [N-1:0]    GNT;
  logic [N-1:0]    DONE;
  logic [N-1:0]    ERR;
  logic            BUSY;
  logic [MW-1:0]   TMR_MIN;
  logic [SW-1:0]   TMR_SEC;
  logic            TMR_START;
  logic            TMR_TIME_UP;

  timer_arbiter #(.N_REQ(N), .MIN_W(MW), .SEC_W(SW)) dut (
    .SYSCLK      (SYSCLK),
    .RST_B       (RST_B),
    .REQ         (REQ),
    .REQ_MIN     (REQ_MIN),
    .REQ_SEC     (REQ_SEC),
    .GNT         (GNT),
    .DONE        (DONE),
    .ERR         (ERR),
    .BUSY        (BUSY),
    .TMR_MIN     (TMR_MIN),
    .TMR_SEC     (TMR_SEC),
    .TMR_START   (TMR_START),
    .TMR_TIME_UP (TMR_TIME_UP)
  );

  always #5 SYSCLK = ~SYSCLK;

  // requester side
  bit rq   [N];
  int rmin [N];
  int rsec [N];

  // model: who owns the timer, for how long, and what is expected next
  int           m_owner;
  int           m_ptr;
  int           m_age;
  bit           m_timed;
  bit           m_expired;
  bit           m_tu_prev;
  logic [N-1:0] e_gnt, e_done, e_err;
  logic         e_busy, e_start;
  int           e_min, e_sec;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cnt_start;
  int           cnt_err;
  int           cnt_done [N];
  int           gnt_order[$];
  logic [N-1:0] prev_gnt;
  int           s2_exp [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ[i]              = rq[i];
      REQ_MIN[i*MW +: MW] = MW'(rmin[i]);
      REQ_SEC[i*SW +: SW] = SW'(rsec[i]);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_age     = 0;
    m_timed   = 0;
    m_expired = 0;
    m_tu_prev = 0;
    e_gnt     = '0;
    e_done    = '0;
    e_err     = '0;
    e_busy    = 0;
    e_start   = 0;
    e_min     = 0;
    e_sec     = 0;
  endtask

  // Expected outputs after the coming rising edge, from the current inputs.
  task automatic model_step();
    int sel;
    bit tu_rise;
    if (!RST_B) begin
      model_reset();
      return;
    end
    tu_rise   = TMR_TIME_UP && !m_tu_prev;
    m_tu_prev = TMR_TIME_UP;
    e_done    = '0;
    e_err     = '0;
    e_start   = 0;
    if (m_owner < 0) begin
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && rq[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      if (sel >= 0) begin
        if (rsec[sel] > 59) begin
          e_err[sel] = 1'b1;
          m_ptr      = (sel + 1) % N;
        end else begin
          m_owner    = sel;
          e_gnt      = '0;
          e_gnt[sel] = 1'b1;
          e_busy     = 1;
          m_age      = 0;
          m_timed    = (rmin[sel] != 0) || (rsec[sel] != 0);
          m_expired  = !m_timed;
          if (m_timed) begin
            e_start = 1;
            e_min   = rmin[sel];
            e_sec   = rsec[sel];
          end
        end
      end
    end else if (m_expired) begin
      e_done[m_owner] = 1'b1;
      e_gnt           = '0;
      e_busy          = 0;
      m_ptr           = (m_owner + 1) % N;
      m_owner         = -1;
    end else if (!rq[m_owner]) begin
      e_gnt   = '0;
      e_busy  = 0;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      // the load cycle (age 0) cannot expire; afterwards only a fresh rise counts
      if (m_age >= 1 && tu_rise) m_expired = 1;
      m_age++;
    end
  endtask

  task automatic check_outputs();
    chk("gnt",       GNT,       e_gnt);
    chk("done",      DONE,      e_done);
    chk("err",       ERR,       e_err);
    chk("busy",      BUSY,      e_busy);
    chk("tmr_start", TMR_START, e_start);
    chk("tmr_min",   TMR_MIN,   e_min);
    chk("tmr_sec",   TMR_SEC,   e_sec);
    chk("one_hot", ($countones(GNT) <= 1) && ($countones(DONE) <= 1) && ($countones(ERR) <= 1), 1);
    if (TMR_START === 1'b1) cnt_start++;
    cnt_err += $countones(ERR);
    for (int i = 0; i < N; i++) begin
      if (DONE[i] === 1'b1) cnt_done[i]++;
      if (GNT[i] === 1'b1 && prev_gnt == '0) gnt_order.push_back(i);
    end
    prev_gnt = GNT;
  endtask

  task automatic tick();
    drive();
    model_step();
    @(negedge SYSCLK);
    check_outputs();
  endtask

  task automatic clr_counts();
    cnt_start = 0;
    cnt_err   = 0;
    for (int i = 0; i < N; i++) cnt_done[i] = 0;
    gnt_order.delete();
  endtask

  task automatic reset_pulse();
    RST_B = 1'b0;
    drive();
    #1;
    model_reset();
    check_outputs();
    tick();
    RST_B = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at time limit, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int r;
    RST_B       = 1'b0;
    TMR_TIME_UP = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i] = 0; rmin[i] = 0; rsec[i] = 0;
    end
    prev_gnt = '0;
    clr_counts();
    model_reset();
    tick();
    chk("rst_gnt",   GNT,       0);
    chk("rst_busy",  BUSY,      0);
    chk("rst_start", TMR_START, 0);
    chk("rst_min",   TMR_MIN,   0);
    chk("rst_sec",   TMR_SEC,   0);
    tick();
    RST_B = 1'b1;

    // single timed request 3:48 on requester 0
    clr_counts();
    rq[0] = 1; rmin[0] = 3; rsec[0] = 48;
    tick();
    chk("s1_gnt",   GNT,       4'b0001);
    chk("s1_start", TMR_START, 1);
    chk("s1_min",   TMR_MIN,   3);
    chk("s1_sec",   TMR_SEC,   48);
    chk("s1_busy",  BUSY,      1);
    tick(); tick(); tick();
    chk("s1_run_start", TMR_START, 0);
    TMR_TIME_UP = 1'b1;
    tick();
    chk("s1_fin_gnt",  GNT,  4'b0001);
    chk("s1_fin_done", DONE, 4'b0000);
    tick();
    chk("s1_done",     DONE, 4'b0001);
    chk("s1_done_gnt", GNT,  4'b0000);
    rq[0] = 0; TMR_TIME_UP = 1'b0;
    tick();
    chk("s1_done_width", DONE,        4'b0000);
    chk("s1_start_cnt",  cnt_start,   1);
    chk("s1_done_cnt",   cnt_done[0], 1);

    // all four requesters held with 0:05, round robin from pointer 0
    reset_pulse();
    clr_counts();
    for (int i = 0; i < N; i++) begin
      rq[i] = 1; rmin[i] = 0; rsec[i] = 5;
    end
    for (int g = 0; g < 5; g++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (e_gnt == '0 && w < 10);
      chk("s2_grant_seen", e_gnt != '0, 1);
      tick(); tick();
      TMR_TIME_UP = 1'b1;
      tick();
      TMR_TIME_UP = 1'b0;
      tick();
    end
    for (int i = 0; i < N; i++) rq[i] = 0;
    tick(); tick();
    chk("s2_order_len", gnt_order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < gnt_order.size()) chk("s2_order", gnt_order[k], s2_exp[k]);
    chk("s2_done0",  cnt_done[0], 2);
    chk("s2_done1",  cnt_done[1], 1);
    chk("s2_done2",  cnt_done[2], 1);
    chk("s2_done3",  cnt_done[3], 1);
    chk("s2_starts", cnt_start,   5);

    // invalid seconds on requester 2
    clr_counts();
    rq[2] = 1; rmin[2] = 1; rsec[2] = 60;
    tick();
    chk("s3_err",   ERR,       4'b0100);
    chk("s3_gnt",   GNT,       4'b0000);
    chk("s3_busy",  BUSY,      0);
    chk("s3_start", TMR_START, 0);
    rq[2] = 0;
    tick();
    chk("s3_err_width", ERR,       4'b0000);
    chk("s3_busy2",     BUSY,      0);
    chk("s3_err_cnt",   cnt_err,   1);
    chk("s3_start_cnt", cnt_start, 0);

    // zero-length request on requester 1
    clr_counts();
    rq[1] = 1; rmin[1] = 0; rsec[1] = 0;
    tick();
    chk("s4_gnt",   GNT,       4'b0010);
    chk("s4_start", TMR_START, 0);
    chk("s4_busy",  BUSY,      1);
    tick();
    chk("s4_done",     DONE, 4'b0010);
    chk("s4_done_gnt", GNT,  4'b0000);
    rq[1] = 0;
    tick();
    chk("s4_start_cnt", cnt_start,   0);
    chk("s4_done_cnt",  cnt_done[1], 1);

    // requester 3 abandons mid-run, pending requester 0 follows
    clr_counts();
    rq[3] = 1; rmin[3] = 2; rsec[3] = 10;
    rq[0] = 1; rmin[0] = 0; rsec[0] = 7;
    tick();
    chk("s5_gnt3", GNT, 4'b1000);
    chk("s5_min3", TMR_MIN, 2);
    tick(); tick();
    rq[3] = 0;
    tick();
    chk("s5_abort_gnt",  GNT,  4'b0000);
    chk("s5_abort_done", DONE, 4'b0000);
    tick();
    chk("s5_gnt0",   GNT,       4'b0001);
    chk("s5_start0", TMR_START, 1);
    chk("s5_sec0",   TMR_SEC,   7);
    tick();
    TMR_TIME_UP = 1'b1;
    tick();
    TMR_TIME_UP = 1'b0;
    tick();
    chk("s5_done0", DONE, 4'b0001);
    rq[0] = 0;
    tick();
    chk("s5_starts", cnt_start,   2);
    chk("s5_no_done3", cnt_done[3], 0);

    // reset in the middle of a run
    clr_counts();
    rq[1] = 1; rmin[1] = 1; rsec[1] = 0;
    tick();
    chk("s6_gnt1", GNT, 4'b0010);
    tick(); tick();
    rq[0] = 1; rmin[0] = 0; rsec[0] = 9;
    RST_B = 1'b0;
    drive();
    #1;
    chk("s6_rst_gnt",   GNT,       0);
    chk("s6_rst_busy",  BUSY,      0);
    chk("s6_rst_start", TMR_START, 0);
    chk("s6_rst_done",  DONE,      0);
    chk("s6_rst_min",   TMR_MIN,   0);
    model_reset();
    check_outputs();
    tick();
    RST_B = 1'b1;
    tick();
    chk("s6_first_gnt", GNT,       4'b0001);
    chk("s6_start",     TMR_START, 1);
    chk("s6_sec",       TMR_SEC,   9);
    rq[0] = 0; rq[1] = 0;
    tick(); tick(); tick();
    chk("s6_no_done", cnt_done[1], 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (e_err[i]) begin
          rq[i] = 0;
        end else if (e_done[i]) begin
          if ($urandom_range(0, 3) != 0) rq[i] = 0;
        end else if (!rq[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            rq[i]   = 1;
            r       = int'($urandom_range(0, 15));
            rmin[i] = int'($urandom_range(0, 7));
            if (r == 0) begin
              rmin[i] = 0; rsec[i] = 0;
            end else if (r == 1) begin
              rsec[i] = int'($urandom_range(60, 63));
            end else begin
              rsec[i] = int'($urandom_range(0, 59));
            end
          end
        end else if (m_owner == i && $urandom_range(0, 63) == 0) begin
          rq[i] = 0;
        end
      end
      if ($urandom_range(0, 4) == 0) TMR_TIME_UP = ~TMR_TIME_UP;
      if ($urandom_range(0, 499) == 0) reset_pulse();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
